// File: rtl/vanity_pkg.sv
// vanity_pkg: shared state encoding and datapath widths for the vanity search chain
package vanity_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  localparam int POINT_W = 256;
  localparam int CNT_W = 64;
  localparam int HASH_W = 160;
endpackage

// File: rtl/vanity_match_fifo.sv
// vanity_match_fifo: match-index FIFO with sticky overflow on dropped pushes
module vanity_match_fifo #(
  parameter int W = 64,
  parameter int DEPTH = 4
) (
  input  logic         mining_clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         empty,
  output logic         overflow
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic full, do_pop, do_push;
  always_comb begin
    empty = wr_ptr == rd_ptr;
    full = wr_ptr == {~rd_ptr[AW], rd_ptr[AW-1:0]};
    do_pop = pop && !empty;
    do_push = push && (!full || do_pop);
    head = mem[rd_ptr[AW-1:0]];
  end
  always_ff @(posedge mining_clk) begin
    if (reset || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= push_data;
        wr_ptr <= wr_ptr + (AW+1)'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + (AW+1)'(1);
      if (push && !do_push) overflow <= 1'b1;
    end
  end
endmodule

// File: rtl/vanity_search_sequencer.sv
// vanity_search_sequencer: runs the adder -> hash -> compare chain and queues matching iteration indices
module vanity_search_sequencer
  import vanity_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CMP_LATENCY = 2
) (
  input  logic               mining_clk,
  input  logic               reset,
  input  logic               rx_start,
  input  logic               rx_stop,
  input  logic [POINT_W-1:0] rx_start_x,
  input  logic [POINT_W-1:0] rx_start_y,
  input  logic [CNT_W-1:0]   rx_iter_limit,
  output logic               tx_adder_reset,
  output logic [POINT_W-1:0] tx_x,
  output logic [POINT_W-1:0] tx_y,
  input  logic               rx_adder_done,
  input  logic [POINT_W-1:0] rx_adder_x,
  input  logic [POINT_W-1:0] rx_adder_y,
  output logic               tx_hash_reset,
  output logic [POINT_W-1:0] tx_hash_x,
  output logic [POINT_W-1:0] tx_hash_y,
  input  logic               rx_hash_done,
  output logic               tx_cmp_reset,
  input  logic               rx_cmp_match,
  output logic               tx_busy,
  output logic [CNT_W-1:0]   tx_cnt,
  output logic               tx_match_valid,
  output logic [CNT_W-1:0]   tx_match_cnt,
  input  logic               rx_match_ack,
  output logic               tx_overflow
);
  localparam int WIN_W = $clog2(CMP_LATENCY + 1);
  state_t state, state_n;
  logic [CNT_W-1:0] limit, hash_tag, cmp_tag;
  logic [WIN_W-1:0] win_cnt;
  logic stop_seen, adder_inflight, hash_busy, hash_done_q, win_active;
  logic start_ok, accept, last, adder_go, hash_rise, win_expire, fifo_empty;
  always_comb begin
    start_ok = state == IDLE && rx_start;
    accept = state == RUN && adder_inflight && rx_adder_done && !tx_adder_reset && !hash_busy;
    last = (limit != '0 && tx_cnt + CNT_W'(1) == limit) || stop_seen || rx_stop;
    adder_go = start_ok || (accept && !last);
    hash_rise = hash_busy && rx_hash_done && !hash_done_q;
    win_expire = win_active && win_cnt == '0;
    tx_busy = state != IDLE;
    tx_match_valid = !fifo_empty;
    state_n = start_ok ? RUN : (accept && last) ? DRAIN :
              (state == DRAIN && !hash_busy && !win_active) ? IDLE : state;
  end
  always_ff @(posedge mining_clk) begin
    if (reset) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge mining_clk) begin
    if (reset) begin
      tx_adder_reset <= 1'b0;
      tx_hash_reset <= 1'b0;
      tx_cmp_reset <= 1'b0;
      tx_x <= '0;
      tx_y <= '0;
      tx_hash_x <= '0;
      tx_hash_y <= '0;
      tx_cnt <= '0;
      limit <= '0;
      hash_tag <= '0;
      cmp_tag <= '0;
      win_cnt <= '0;
      stop_seen <= 1'b0;
      adder_inflight <= 1'b0;
      hash_busy <= 1'b0;
      hash_done_q <= 1'b0;
      win_active <= 1'b0;
    end else begin
      tx_adder_reset <= adder_go;
      tx_hash_reset <= accept;
      tx_cmp_reset <= hash_rise;
      hash_done_q <= rx_hash_done;
      adder_inflight <= adder_go || (adder_inflight && !accept);
      hash_busy <= accept || (hash_busy && !hash_rise);
      win_active <= hash_rise || (win_active && !win_expire);
      win_cnt <= hash_rise ? WIN_W'(CMP_LATENCY) : win_cnt - WIN_W'(win_cnt != '0);
      if (state == RUN && rx_stop) stop_seen <= 1'b1;
      if (hash_rise) cmp_tag <= hash_tag;
      if (start_ok) begin
        tx_x <= rx_start_x;
        tx_y <= rx_start_y;
        tx_cnt <= '0;
        limit <= rx_iter_limit;
        stop_seen <= 1'b0;
      end
      if (accept) begin
        tx_x <= rx_adder_x;
        tx_y <= rx_adder_y;
        tx_hash_x <= rx_adder_x;
        tx_hash_y <= rx_adder_y;
        hash_tag <= tx_cnt;
        tx_cnt <= tx_cnt + CNT_W'(1);
      end
    end
  end
  vanity_match_fifo #(.W(CNT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .mining_clk(mining_clk),
    .reset(reset),
    .clear(start_ok),
    .push(win_expire && rx_cmp_match),
    .push_data(cmp_tag),
    .pop(rx_match_ack),
    .head(tx_match_cnt),
    .empty(fifo_empty),
    .overflow(tx_overflow)
  );
endmodule
